// File: rtl/rr_log_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_log_arbiter_pkg
// Description : Shared types and constants for the round-robin log arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_log_arbiter_pkg;

    // Arbiter FSM: IDLE arbitrates, GRANT streams beats from one requester
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

    // Width of the per-burst beat counter (MAX_BURST is limited to 255)
    localparam int RR_ARB_MAX_BURST_BITS = 8;

    // Width of the free-running accepted-beat counter
    localparam int RR_ARB_BEAT_CNT_W = 32;

endpackage : rr_log_arbiter_pkg
`default_nettype wire

// File: rtl/rr_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of the valid vector scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_rr_pick
    import rr_log_arbiter_pkg::*;
#(
    parameter  int N_REQ   = 4,
    localparam int c_idx_w = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]   valid,
    input  logic [c_idx_w-1:0] rr_ptr,
    output logic [c_idx_w-1:0] index,
    output logic               any_valid
);

    // One extra bit so rr_ptr + k never overflows before the modulo fold
    logic [c_idx_w:0] w_cand;
    logic             w_found;

    // Scan candidates in priority order starting at rr_ptr; first hit wins
    always_comb begin
        index   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, rr_ptr} + (c_idx_w + 1)'(k);
            if (w_cand >= (c_idx_w + 1)'(N_REQ)) begin
                w_cand = w_cand - (c_idx_w + 1)'(N_REQ);
            end
            if (!w_found && valid[w_cand[c_idx_w-1:0]]) begin
                index   = w_cand[c_idx_w-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign any_valid = |valid;

endmodule : rr_rr_pick
`default_nettype wire

// File: rtl/rr_log_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_log_arbiter
// Description : Round-robin arbiter merging N_REQ logging beat streams into
//               one registered output stream. Each grant carries a burst of
//               up to MAX_BURST beats; an IDLE cycle separates grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_log_arbiter
    import rr_log_arbiter_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 64,
    parameter  int MAX_BURST = 4,
    localparam int c_idx_w   = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [c_idx_w-1:0]           out_id,
    input  logic                         out_ready,
    output logic [RR_ARB_BEAT_CNT_W-1:0] beat_cnt
);

    localparam logic [RR_ARB_MAX_BURST_BITS-1:0] c_burst_last =
        RR_ARB_MAX_BURST_BITS'(MAX_BURST - 1);

    // Reject parameter sets the counters and picker cannot represent
    if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
        $error("rr_log_arbiter: N_REQ must be 2..16 and MAX_BURST must be 1..255");
    end

    rr_state_t                        r_state;
    logic [c_idx_w-1:0]               r_grant;
    logic [c_idx_w-1:0]               r_rr_ptr;
    logic [RR_ARB_MAX_BURST_BITS-1:0] r_burst_cnt;
    logic [RR_ARB_BEAT_CNT_W-1:0]     r_beat_cnt;

    logic [c_idx_w-1:0]               w_pick_index;
    logic                             w_pick_any;
    logic                             w_grant_ready;
    logic                             w_accept;
    logic                             w_burst_end;
    logic [c_idx_w-1:0]               w_next_ptr;
    logic [DATA_W-1:0]                w_sel_data;

    rr_rr_pick #(
        .N_REQ     (N_REQ)
    ) u_pick (
        .valid     (req_valid),
        .rr_ptr    (r_rr_ptr),
        .index     (w_pick_index),
        .any_valid (w_pick_any)
    );

    // The granted requester may push whenever the output register is free
    // or being drained this cycle
    assign w_grant_ready = (r_state == GRANT) && (!out_valid || out_ready);
    assign w_accept      = w_grant_ready && req_valid[r_grant];

    // Burst closes on the last allowed beat, or when the owner goes quiet
    // while the output register is able to move
    assign w_burst_end = (w_accept && (r_burst_cnt == c_burst_last)) ||
                         ((r_state == GRANT) && !req_valid[r_grant] &&
                          (!out_valid || out_ready));

    assign w_next_ptr = (r_grant == c_idx_w'(N_REQ - 1)) ? '0 : r_grant + c_idx_w'(1);

    assign beat_cnt = r_beat_cnt;

    // One-hot ready toward the granted requester only
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == c_idx_w'(i)) begin
                req_ready[i] = w_grant_ready;
            end
        end
    end

    // Mux the granted requester's data lane
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == c_idx_w'(i)) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbiter FSM with registered output beat and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_id      <= '0;
        end else begin
            if (w_accept) begin
                out_valid   <= 1'b1;
                out_data    <= w_sel_data;
                out_id      <= r_grant;
                r_burst_cnt <= r_burst_cnt + 1'b1;
                r_beat_cnt  <= r_beat_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant     <= w_pick_index;
                        r_burst_cnt <= '0;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_burst_end) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : rr_log_arbiter
`default_nettype wire

// File: tb/tb_rr_log_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_log_arbiter
// Description : Self-checking bench for rr_log_arbiter with a transaction-
//               level reference model and directed plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_log_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int MB = 4;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_data;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [IW-1:0]     out_id;
    logic              out_ready;
    logic [31:0]       beat_cnt;
    logic [W-1:0]      dat [N];

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the link, where the pointer is, the beat
    // sitting in the output register, and the running beat total
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    bit          m_ov;
    logic [W-1:0] m_od;
    int          m_oid;
    logic [31:0] m_beats;

    rr_log_arbiter #(
        .N_REQ     (N),
        .DATA_W    (W),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    // Pack the per-requester data lanes
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_ov = 0; m_od = '0; m_oid = 0; m_beats = '0;
    endtask

    function automatic int m_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) dat[i] = {$urandom, $urandom};
    endtask

    // Compare DUT against the model, then advance the model across one edge
    task automatic step();
        logic [N-1:0] exp_rdy;
        bit acc, fin;
        int p;
        #1;
        exp_rdy = '0;
        if (m_busy && (!m_ov || out_ready)) exp_rdy[m_owner] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("beat_cnt", 64'(beat_cnt), 64'(m_beats));
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_id", 64'(out_id), 64'(m_oid));
        end
        @(posedge clk);
        acc = m_busy && req_valid[m_owner] && (!m_ov || out_ready);
        if (!m_busy) begin
            p = m_pick(req_valid);
            if (p >= 0) begin
                m_owner = p; m_cnt = 0; m_busy = 1;
            end
        end else begin
            fin = (acc && m_cnt == MB - 1) || (!req_valid[m_owner] && (!m_ov || out_ready));
            if (acc) m_cnt++;
            if (fin) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        if (acc) begin
            m_ov = 1; m_od = dat[m_owner]; m_oid = m_owner; m_beats = m_beats + 32'd1;
        end else if (out_ready) begin
            m_ov = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        #1;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [10:0] hist;
        int ids[$];
        int n2, first_other, first_id;
        logic [W-1:0] d_beat, d_next;

        rst = 1'b1; req_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester: bursts of 4 with one bubble
        req_valid = 4'b0001; out_ready = 1'b1;
        hist = '0;
        hist[0] = out_valid;
        for (int k = 1; k <= 10; k++) begin
            rand_data();
            step();
            hist[k] = out_valid;
            if (out_valid) chk("single_id", 64'(out_id), 64'd0);
            if (k == 10) chk("single_beats10", 64'(beat_cnt), 64'd8);
        end
        chk("single_valid_pattern", 64'(hist), 64'(11'b11110111100));

        // All requesters: round-robin order with pointer wrap
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        ids = {};
        repeat (25) begin
            rand_data();
            step();
            if (out_valid) ids.push_back(int'(out_id));
        end
        chk("rr_seq_len_ok", 64'(ids.size() >= 17), 64'd1);
        for (int j = 0; j < 17 && j < ids.size(); j++) begin
            chk($sformatf("rr_seq[%0d]", j), 64'(ids[j]), 64'((j / 4) % 4));
        end

        // Requester 2 drops after two beats; 3 must follow
        do_reset();
        out_ready = 1'b1;
        n2 = 0; first_other = -1;
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 3) ? 4'b0100 : 4'b1001;
            rand_data();
            step();
            if (out_valid) begin
                if (out_id == 2'd2) n2++;
                else if (first_other < 0) first_other = int'(out_id);
            end
        end
        chk("drop_beats_id2", 64'(n2), 64'd2);
        chk("drop_next_id", 64'(first_other), 64'd3);

        // Backpressure hold then back-to-back resume
        do_reset();
        req_valid = 4'b0001; out_ready = 1'b1;
        rand_data(); step();
        rand_data(); d_beat = dat[0]; step();
        out_ready = 1'b0;
        repeat (5) begin
            rand_data();
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, d_beat);
            chk("hold_id", 64'(out_id), 64'd0);
            chk("hold_ready", 64'(req_ready), 64'd0);
            chk("hold_beats", 64'(beat_cnt), 64'd1);
        end
        out_ready = 1'b1;
        rand_data(); d_next = dat[0];
        step();
        chk("resume_valid", 64'(out_valid), 64'd1);
        chk("resume_data", out_data, d_next);
        chk("resume_beats", 64'(beat_cnt), 64'd2);

        // Asynchronous reset mid-grant
        do_reset();
        req_valid = 4'b0110; out_ready = 1'b1;
        repeat (3) begin rand_data(); step(); end
        chk("pre_arst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1010;
        rst = 1'b0;
        first_id = -1;
        repeat (6) begin
            rand_data();
            step();
            if (out_valid && first_id < 0) first_id = int'(out_id);
        end
        chk("arst_first_id", 64'(first_id), 64'd1);

        // beat_cnt wrap
        do_reset();
        force dut.r_beat_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_beat_cnt;
        m_beats = 32'hFFFF_FFFE;
        req_valid = 4'b0001; out_ready = 1'b1;
        repeat (4) begin rand_data(); step(); end
        chk("wrap_beat_cnt", 64'(beat_cnt), 64'd1);

        // Randomized traffic against the model
        do_reset();
        repeat (3000) begin
            for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            step();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_log_arbiter
`default_nettype wire

// File: doc/rr_log_arbiter.md
RR_LOG_ARBITER -- requirements
Module: rr_log_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of logging requesters (2..16).
REQ-002 SHALL have parameter DATA_W, default 64, data width per requester beat.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats per grant (1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, N_REQ, per-requester beat valid.
REQ-007 SHALL have port req_data, input, N_REQ*DATA_W, requester i data at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready, output, N_REQ, per-requester accept.
REQ-009 SHALL have port out_valid, output, 1, registered output beat valid.
REQ-010 SHALL have port out_data, output, DATA_W, registered output data.
REQ-011 SHALL have port out_id, output, $clog2(N_REQ), source index of the output beat.
REQ-012 SHALL have port out_ready, input, 1, downstream accept.
REQ-013 SHALL have port beat_cnt, output, 32, total beats accepted from all requesters.

Function
REQ-014 SHALL implement the FSM states IDLE and GRANT, with registers grant (index), rr_ptr (index) and burst_cnt (8 bits).
REQ-015 In IDLE with any req_valid high, SHALL select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ, latch it into grant, clear burst_cnt, and enter GRANT next cycle.
REQ-016 In IDLE, all req_ready SHALL be 0; with no req_valid high, the FSM SHALL stay in IDLE.
REQ-017 req_ready[i] SHALL equal (state==GRANT && grant==i && (!out_valid || out_ready)), and all other bits SHALL be 0.
REQ-018 Accept SHALL be req_valid[grant] && req_ready[grant]; on accept, SHALL load out_data/out_id from that requester, set out_valid next cycle (1-cycle latency), and increment burst_cnt and beat_cnt.
REQ-019 With out_valid high and out_ready low, out_valid/out_data/out_id SHALL remain stable, and no new accept SHALL occur.
REQ-020 On out_ready high with no accept in the same cycle, out_valid SHALL clear; with an accept in the same cycle, the new beat SHALL replace the old with no bubble.
REQ-021 A burst SHALL end when (a) an accept occurs with burst_cnt==MAX_BURST-1, or (b) in GRANT, req_valid[grant] is 0 and out_valid is 0 or out_ready is 1.
REQ-022 On burst end, the FSM SHALL enter IDLE, and rr_ptr SHALL become (grant+1) mod N_REQ; wrap from N_REQ-1 SHALL give 0.
REQ-023 The arbiter SHALL always pass through IDLE between grants, so at most one bubble cycle separates bursts.
REQ-024 beat_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 Requesters SHALL hold req_data stable while req_valid is high and unaccepted; the arbiter SHALL NOT check this.
REQ-026 A requester continuously valid SHALL be granted within N_REQ-1 other bursts (starvation bound).

Reset
REQ-027 On rst, SHALL immediately enter IDLE and set rr_ptr=0, grant=0, burst_cnt=0, out_valid=0, out_data=0, out_id=0, beat_cnt=0, with req_ready all 0.
REQ-028 Reset asserted mid-burst SHALL discard any held output beat; after deassertion, arbitration SHALL restart from index 0.

Structure
REQ-029 The shared rr package SHALL hold the FSM state enum, RR_ARB_MAX_BURST_BITS=8, and the beat_cnt width constant.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_rr_pick (inputs: valid vector, rr_ptr; outputs: index, any_valid).
REQ-031 An elaboration-time $error SHALL be raised if N_REQ<2 or MAX_BURST==0.

Verification
REQ-032 The bench SHALL cover: reset, then req_valid=4'b0001 continuously with out_ready=1 -> bursts of 4 beats with out_id=0, one IDLE bubble between bursts, and beat_cnt=8 after 10 cycles.
REQ-033 The bench SHALL cover: req_valid=4'b1111 continuously with out_ready=1 -> out_id sequence 0,0,0,0,1,1,1,1,2,...,3 then 0; rr_ptr wraps 3->0.
REQ-034 The bench SHALL cover: requester 2 drops valid after 2 beats -> burst ends, next grant is 3 (rr_ptr=3), and only 2 beats are counted for id 2.
REQ-035 The bench SHALL cover: out_ready=0 for 5 cycles with a beat held -> out_data/out_id stable, req_ready all 0, beat_cnt unchanged; out_ready=1 -> next beat follows back-to-back.
REQ-036 The bench SHALL cover: rst asserted in GRANT with out_valid=1 -> out_valid=0 in the same cycle (asynchronous), and the first grant after release is the lowest valid index.
REQ-037 The bench SHALL cover: beat_cnt preloaded (via force) to 0xFFFFFFFE and 3 beats accepted -> beat_cnt=1.
